// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-serialised data-memory word port.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_LAST,
    RESP
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Big-endian lane select: lane 0 is the most significant byte of the word.
  function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] lane;
    case (k)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/dmem_word_port.sv
// Multi-cycle port that splits 32-bit loads/stores into four big-endian byte
// beats against a byte-wide synchronous memory and answers over valid/ready.
module dmem_word_port
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t              state_reg, state_next;
  logic [1:0]          beat_reg, beat_next;
  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W-1:0]   addr_hold_reg;
  logic [ADDR_W-1:0]   beat_addr;
  logic [31:0]         wdata_reg;
  logic                write_reg;
  logic                err_reg;
  logic                req_bad;
  logic                accept;
  logic                cap_en;
  logic [1:0]          cap_idx;
  logic [31:0]         rword;

  // Misaligned or beyond the memory: rejected without touching memory.
  assign req_bad   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W] != '0);
  assign accept    = req_valid && (state_reg == IDLE);
  // Aligned words never cross the top of memory, so no wrap handling needed.
  assign beat_addr = base_reg + ADDR_W'(beat_reg);

  // Next-state, beat sequencing and all handshake/memory outputs.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    mem_addr   = addr_hold_reg;
    cap_en     = 1'b0;
    cap_idx    = 2'd0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        beat_next = 2'd0;
        if (req_valid) begin
          if (req_bad)        state_next = RESP;
          else if (req_write) state_next = WR;
          else                state_next = RD;
        end
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = be_lane(wdata_reg, beat_reg);
        beat_next = beat_reg + 2'd1;
        if (beat_reg == 2'd3) state_next = RESP;
      end
      RD: begin
        mem_addr  = beat_addr;
        // Read data lags the address by one cycle, so beat k yields byte k-1.
        cap_en    = (beat_reg != 2'd0);
        cap_idx   = beat_reg - 2'd1;
        beat_next = beat_reg + 2'd1;
        if (beat_reg == 2'd3) state_next = RD_LAST;
      end
      RD_LAST: begin
        cap_en     = 1'b1;
        cap_idx    = 2'd3;
        beat_next  = 2'd0;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load data only leaves the block for successful loads.
  assign resp_rdata = (state_reg == RESP && !err_reg && !write_reg) ? rword : 32'h0;
  assign resp_err   = (state_reg == RESP) && err_reg;

  // FSM state and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  // Request fields are sampled only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg  <= '0;
      wdata_reg <= 32'h0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      base_reg  <= req_addr[ADDR_W-1:0];
      wdata_reg <= req_wdata;
      write_reg <= req_write;
      err_reg   <= req_bad;
    end
  end

  // Remember the last beat address so mem_addr is steady between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 addr_hold_reg <= '0;
    else if (state_reg == WR || state_reg == RD) addr_hold_reg <= beat_addr;
  end

  // One capture register per byte lane of the assembled load word.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    logic [7:0] byte_reg;

    // Clear on accept, then capture this lane when its read beat returns.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             byte_reg <= 8'h00;
      else if (accept)                        byte_reg <= 8'h00;
      else if (cap_en && cap_idx == 2'(gi))   byte_reg <= mem_rdata;
    end

    assign rword[31-8*gi -: 8] = byte_reg;
  end

endmodule

// File: tb/tb_dmem_word_port.sv
// Scoreboard bench for dmem_word_port: directed requests push expected
// responses and memory beats; a negedge monitor pops and compares them.
module tb_dmem_word_port;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  dmem_word_port #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] mem [64];
  logic       init_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory with synchronous read; preloaded on the first edge.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[16] <= 8'h11;
      mem[17] <= 8'h22;
      mem[18] <= 8'h33;
      mem[19] <= 8'h44;
      mem[34] <= 8'h55;
      mem[35] <= 8'h66;
      init_done <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: memory beats and responses against the scoreboard queues.
  logic seen_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else begin
      if (mem_we) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          chk("beat_addr", 32'(mem_addr), 32'(beat_q[0].a));
          chk("beat_data", 32'(mem_wdata), 32'(beat_q[0].d));
          $display("beat: addr=%h data=%h", mem_addr, mem_wdata);
          void'(beat_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            chk("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
          end else begin
            chk("hold_rdata", resp_rdata, exp_q[0].rdata);
            chk("hold_err", {31'h0, resp_err}, {31'h0, exp_q[0].err});
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
          end
          if (resp_ready) begin
            chk("resp_rdata", resp_rdata, exp_q[0].rdata);
            chk("resp_err", {31'h0, resp_err}, {31'h0, exp_q[0].err});
            $display("resp: rdata=%h err=%0d", resp_rdata, resp_err);
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  // Present one request; called #1 after a rising edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input int nbeats, input logic push_resp);
    bit got = 0;
    exp_t  e;
    beat_t b;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) begin
        got = 1;
        if (push_resp) begin
          e.rdata = exp_rdata;
          e.err   = exp_err;
          e.acc   = cyc + 1;
          e.lat   = lat;
          exp_q.push_back(e);
        end
        for (int k = 0; k < nbeats; k++) begin
          b.a = addr[ADDR_W-1:0] + ADDR_W'(k);
          b.d = 8'(wdata >> (24 - 8 * k));
          beat_q.push_back(b);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    $display("req: write=%0d addr=%h wdata=%h", wr, addr, wdata);
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("resp_pending", 32'(exp_q.size()), 32'h0);
    chk("beats_pending", 32'(beat_q.size()), 32'h0);
    exp_q.delete();
    beat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store, load, and two rejected loads.
    issue(1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4, 1'b1);
    wait_done();
    issue(1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 6, 0, 1'b1);
    wait_done();
    issue(1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 6, 0, 1'b1);
    wait_done();
    issue(1'b0, 32'h0A, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);
    wait_done();
    issue(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);
    wait_done();

    // Backpressure on a load, then a store right after release.
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 6, 0, 1'b1);
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    issue(1'b1, 32'h04, 32'h01020304, 32'h0, 1'b0, 5, 4, 1'b1);
    wait_done();
    chk("mem_04", 32'(mem[4]), 32'h01);
    chk("mem_07", 32'(mem[7]), 32'h04);

    // Reset during beat 2 of a store.
    issue(1'b1, 32'h20, 32'hA1B2C3D4, 32'h0, 1'b0, 5, 2, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_beats_left", 32'(beat_q.size()), 32'h0);
    chk("abort_mem_20", 32'(mem[32]), 32'hA1);
    chk("abort_mem_21", 32'(mem[33]), 32'hB2);
    chk("abort_mem_22", 32'(mem[34]), 32'h55);
    chk("abort_mem_23", 32'(mem[35]), 32'h66);

    // Top word of memory.
    issue(1'b1, 32'h3C, 32'hCAFEF00D, 32'h0, 1'b0, 5, 4, 1'b1);
    wait_done();
    issue(1'b0, 32'h3C, 32'h0, 32'hCAFEF00D, 1'b0, 6, 0, 1'b1);
    wait_done();
    chk("mem_00_untouched", 32'(mem[0]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_word_port.md
Name: dmem_word_port

Overview:
- Multi-cycle data-memory port between the processor's execute stage (effective address, store data, load/store strobe) and a byte-wide data memory of 2^ADDR_W bytes.
- Serialises each 32-bit load/store into four big-endian byte beats: byte at base holds bits 31:24, byte at base+3 holds bits 7:0.
- Returns the assembled load word, or a store acknowledge, over a valid/ready response handshake so the core can stall.

Parameters:
ADDR_W, 6, byte-address width of the data memory (depth 2^ADDR_W = 64 bytes).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address of word
req_wdata  in  32  store data
resp_valid  out  1  response present
resp_ready  in  1  core consumes response
resp_rdata  out  32  load word (0 for stores and errors)
resp_err  out  1  request rejected (misaligned or out of range)
mem_addr  out  ADDR_W  byte address to memory
mem_we  out  1  byte write strobe
mem_wdata  out  8  byte write data
mem_rdata  in  8  byte read data, synchronous: valid the cycle after mem_addr is driven

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, beat counter=0.
  - Reset mid-store aborts immediately. Bytes already written stay written; no response is issued.
- States:
  - IDLE: req_ready=1. Accept when req_valid && req_ready; latch addr, wdata and write flag.
    - Misaligned (addr[1:0]!=0) or out of range (addr[31:ADDR_W]!=0): go to RESP with err=1. No memory access occurs.
    - Otherwise: go to WR on a store, RD on a load.
  - WR: 4 cycles, beat k=0..3.
    - mem_we=1, mem_addr=base+k.
    - mem_wdata = wdata[31-8k -: 8].
    - After k=3, go to RESP.
  - RD: 4 cycles driving mem_addr=base+k, mem_we=0.
    - For k>=1, capture mem_rdata into byte k-1 of the word.
    - After k=3, go to RD_LAST.
  - RD_LAST: 1 cycle; capture byte 3; go to RESP.
  - RESP: resp_valid=1 with rdata/err held stable until resp_ready=1. On that edge go to IDLE.
- Latency, counted from the accept edge:
  - Store: resp_valid in cycle 5.
  - Load: resp_valid in cycle 6.
  - Error: resp_valid in cycle 1.
  - If resp_ready is already high, the next request can be accepted 1 cycle after resp_valid.
- Throughput: one outstanding request; req_ready=0 in every state except IDLE.
- Address arithmetic: base+k is computed in ADDR_W bits. Aligned accesses never wrap inside a word.
- mem_we is 0 in every state except WR; mem_addr holds its last value when idle.
- resp_rdata=0 for stores and errors. resp_err=0 for successful accesses.
- req_valid deasserting in a non-IDLE state has no effect; request fields are sampled only at accept.

Decomposition:
- Shared package dmem_pkg:
  - state enum IDLE/WR/RD/RD_LAST/RESP.
  - BYTES_PER_WORD=4.
  - Big-endian byte-lane select function (lane k -> bits 31-8k..24-8k).
- No sub-module: FSM, beat counter and word assembly fit in one module.

Test Plan:
- Store 0xDEADBEEF to addr 0x08 -> mem_we beats at addr 8,9,10,11 with data DE,AD,BE,EF; resp_valid in cycle 5, resp_err=0, resp_rdata=0.
- Memory preloaded 11,22,33,44 at 0x10..0x13; load 0x10 -> resp_rdata=0x11223344 in cycle 6, no mem_we.
- Load 0x0A (misaligned) and load 0x40 (out of range) -> resp_valid in cycle 1, resp_err=1, no memory beats.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0. Raise resp_ready -> IDLE next cycle, back-to-back store then accepted.
- Assert rst_n=0 during WR beat 2 of a store of 0xA1B2C3D4 to 0x20 -> mem_we drops immediately, mem[0x20]=A1, mem[0x21]=B2, 0x22/0x23 unchanged, no response, req_ready=1 after release.
- Store to 0x3C then load 0x3C (top word) -> same value returned, addresses 0x3C..0x3F with no wrap.
